// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 16x16 multiplier between two requesters.
// Define MUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins a tie).
module mul_share_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iReq0,
   input  logic [15:0] iA0,
   input  logic [15:0] iB0,
   input  logic        iReq1,
   input  logic [15:0] iA1,
   input  logic [15:0] iB1,
   output logic        oGnt0,
   output logic        oGnt1,
   output logic        oDone0,
   output logic        oDone1,
   output logic [31:0] oResult,
   output logic        oBusy
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
   state_t state, state_nxt;
   logic [15:0] op_a, op_b;
   logic [3:0] cnt;
   logic owner, win1, grant, finish;
   logic [31:0] prod;
`ifdef MUL_ARB_FIXED_PRIO_EN
   assign win1 = iReq1 & ~iReq0;
`else
   logic ptr;
   // ptr holds the last granted requester; a tie goes to the other one
   assign win1 = iReq1 & (~iReq0 | ~ptr);
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) ptr <= 1'b1;
      else if (grant) ptr <= win1;
`endif
   assign grant  = (state == IDLE) & (iReq0 | iReq1);
   assign finish = (state == BUSY) & (cnt == 4'd1);
   assign prod   = 32'(op_a) * 32'(op_b);
   assign oBusy  = state == BUSY;
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) state <= IDLE;
      else state <= state_nxt;
   always_comb state_nxt = grant ? BUSY : finish ? IDLE : state;
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) begin
         op_a    <= '0;
         op_b    <= '0;
         cnt     <= '0;
         owner   <= 1'b0;
         oGnt0   <= 1'b0;
         oGnt1   <= 1'b0;
         oDone0  <= 1'b0;
         oDone1  <= 1'b0;
         oResult <= '0;
      end else begin
         oGnt0  <= grant & ~win1;
         oGnt1  <= grant & win1;
         oDone0 <= finish & ~owner;
         oDone1 <= finish & owner;
         if (grant) begin
            op_a  <= win1 ? iA1 : iA0;
            op_b  <= win1 ? iB1 : iB0;
            cnt   <= WAIT_LD;
            owner <= win1;
         end else if (state == BUSY) cnt <= cnt - 4'd1;
         if (finish) oResult <= prod;
      end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one 16x16 unsigned multiplier between two requesters. It captures the winning requester's operands, lets the combinational product settle for a configurable number of cycles, then registers the 32-bit result and returns it with a one-cycle done strobe. It sits between two client blocks (for example, a pixel-address generator and a scaling unit) and the array-multiplier datapath, so only one multiplier instance is needed.

## Interface
- WAIT_CYCLES, 2, cycles from operand capture to result capture (multicycle settle for the combinational multiplier); legal range 1..15.

- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- iReq0  in  1  request from requester 0; level, sampled only in IDLE.
- iA0  in  16  multiplicand, requester 0.
- iB0  in  16  multiplier, requester 0.
- iReq1  in  1  request from requester 1.
- iA1  in  16  multiplicand, requester 1.
- iB1  in  16  multiplier, requester 1.
- oGnt0  out  1  one-cycle pulse: requester 0's operands were captured.
- oGnt1  out  1  one-cycle pulse: requester 1's operands were captured.
- oDone0  out  1  one-cycle pulse: oResult is valid for requester 0.
- oDone1  out  1  one-cycle pulse: oResult is valid for requester 1.
- oResult  out  32  registered product; holds its value until the next completion.
- oBusy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Two states:
  - IDLE: sample iReq0/iReq1. If either is high, grant a winner, latch its A/B into the operand registers, load the wait counter with WAIT_CYCLES, record the owner, and go to BUSY.
  - BUSY: decrement the counter each cycle. At the edge where the counter equals 1, register the multiplier output into oResult, pulse oDone of the owner, and return to IDLE.
- Arbitration when only one requester is high: that requester wins.
- Arbitration when both are high: the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- The pointer updates on every grant.
- Arithmetic: oResult = A*B, unsigned and exact. The full 32 bits are kept, with no truncation or saturation.
- Operands are registered, so requesters may change iA/iB or drop iReq freely once they see oGnt.
- iReq is ignored in BUSY. A request raised during BUSY is served at the next IDLE sample.
- A requester that still has iReq high at the IDLE sample after its oDone starts a new transaction. To avoid this, it must deassert iReq no later than the cycle oDone is high.
- Reset values: oGnt0=oGnt1=oDone0=oDone1=0, oBusy=0, oResult=32'h0, state=IDLE, counter=0, pointer=1.

## Timing
- The operand-capture edge is E. oGntX is high for the single cycle after E, and oBusy rises in that same cycle.
- oResult updates and oDoneX rises at edge E+WAIT_CYCLES. oDoneX is high for exactly one cycle. oBusy falls at that same edge.
- The earliest next capture edge is E+WAIT_CYCLES+1.
- Sustained throughput is one product per WAIT_CYCLES+1 cycles.
- oGnt and oDone are never high together for the same transaction. oGnt0 and oGnt1 are mutually exclusive, and so are oDone0 and oDone1.
- Reset asserted mid-BUSY aborts the transaction: no oDone, oResult cleared to 0, pointer returns to 1.
- Reset release: the first IDLE sample happens at the first rising edge with Reset low.

## Configuration
- MUL_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. Requester 0 always wins a tie and the pointer logic is removed.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single request, WAIT_CYCLES=2: iReq0=1, A0=3, B0=5.
  - oGnt0 is high one cycle after the capture edge.
  - 2 edges after capture, oResult=15 and oDone0 is high for 1 cycle. oBusy is high for 2 cycles.
- Worst-case width: A1=16'hFFFF, B1=16'hFFFF → oResult=32'hFFFE0001 with oDone1.
- Both requesting continuously, round-robin build, A0=2,B0=3 and A1=4,B1=5:
  - Grants go 0,1,0,1.
  - Results alternate 6 and 20, every 3 cycles.
  - oDone owner matches the grant owner.
- The same stimulus with MUL_ARB_FIXED_PRIO_EN defined gives grants 0,0,0. Requester 1 is never granted while iReq0 stays high.
- Reset mid-op: with the first stimulus, assert Reset 1 cycle after oGnt0.
  - Outputs go to 0 immediately and no oDone0 appears.
  - After release, a fresh 7*8 request completes with oResult=56.
- Late request: iReq1 rises while BUSY serving requester 0.
  - It is ignored until IDLE.
  - oGnt1 follows oDone0 by exactly 1 cycle (capture at E+WAIT_CYCLES+1).
